// File: rtl/unary_stream_decoder.sv
// Unary stream decoder: counts ones over a window of 2^BITWIDTH valid samples
// and hands the binary result over a valid/ready handshake. oClr re-aligns the upstream RNG.
module unary_stream_decoder #(
  parameter int BITWIDTH = 8
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic              iAbort,
  input  logic              iBit,
  input  logic              iBitValid,
  input  logic              iReady,
  output logic              oClr,
  output logic              oBusy,
  output logic              oValid,
  output logic [BITWIDTH:0] oCount
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_DONE
  } state_e;

  // Index of the last sample in a window: 2^BITWIDTH - 1.
  localparam logic [BITWIDTH:0] LAST_IDX = {1'b0, {BITWIDTH{1'b1}}};
  localparam logic [BITWIDTH:0] CNT_ONE  = {{BITWIDTH{1'b0}}, 1'b1};
  localparam logic [BITWIDTH:0] CNT_ZERO = '0;

  state_e            state_q;
  logic [BITWIDTH:0] sample_cnt_q, sample_cnt_d;
  logic [BITWIDTH:0] acc_q, acc_d;
  logic [BITWIDTH:0] count_q;
  logic              clr_q, busy_q, valid_q;
  logic              last_sample;

  // NOTE: every variable written here gets its value unconditionally, so no latch is inferred.
  always_comb begin
    sample_cnt_d = sample_cnt_q + CNT_ONE;
    acc_d        = acc_q + {{BITWIDTH{1'b0}}, iBit};
    last_sample  = (sample_cnt_q == LAST_IDX);
  end

  // NOTE: state and outputs update with non-blocking assignments so all of them see pre-edge values.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q      <= S_IDLE;
      sample_cnt_q <= CNT_ZERO;
      acc_q        <= CNT_ZERO;
      count_q      <= CNT_ZERO;
      clr_q        <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else if (iAbort) begin
      // Abort beats start and window-end; the last result is left in count_q but is not valid.
      state_q      <= S_IDLE;
      sample_cnt_q <= CNT_ZERO;
      acc_q        <= CNT_ZERO;
      clr_q        <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (iStart) begin
            state_q      <= S_CLR;
            sample_cnt_q <= CNT_ZERO;
            acc_q        <= CNT_ZERO;
            clr_q        <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        S_CLR: begin
          state_q <= S_RUN;
          clr_q   <= 1'b0;
        end
        S_RUN: begin
          if (iBitValid) begin
            sample_cnt_q <= sample_cnt_d;
            acc_q        <= acc_d;
            if (last_sample) begin
              // The final sample is folded into the result on the same edge.
              state_q <= S_DONE;
              count_q <= acc_d;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (iReady) begin
            valid_q <= 1'b0;
            if (iStart) begin
              state_q      <= S_CLR;
              sample_cnt_q <= CNT_ZERO;
              acc_q        <= CNT_ZERO;
              clr_q        <= 1'b1;
              busy_q       <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          clr_q   <= 1'b0;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign oClr   = clr_q;
  assign oBusy  = busy_q;
  assign oValid = valid_q;
  assign oCount = count_q;

endmodule

// File: tb/tb_unary_stream_decoder.sv
// Self-checking bench for unary_stream_decoder: directed sequence with random stimulus,
// expected counts come from summing the accepted window bits.
module tb_unary_stream_decoder;

  localparam int BITWIDTH = 8;
  localparam int WINDOW   = 1 << BITWIDTH;

  logic              iClk = 1'b0;
  logic              iRst;
  logic              iStart;
  logic              iAbort;
  logic              iBit;
  logic              iBitValid;
  logic              iReady;
  logic              oClr;
  logic              oBusy;
  logic              oValid;
  logic [BITWIDTH:0] oCount;

  int tests_run = 0;
  int tests_failed = 0;
  int last_result = 0;

  unary_stream_decoder #(.BITWIDTH(BITWIDTH)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iStart    (iStart),
    .iAbort    (iAbort),
    .iBit      (iBit),
    .iBitValid (iBitValid),
    .iReady    (iReady),
    .oClr      (oClr),
    .oBusy     (oBusy),
    .oValid    (oValid),
    .oCount    (oCount)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // From IDLE: pulse iStart, check the CLR cycle, drive a sample during CLR that must be ignored.
  task automatic start_window(input logic clr_bit);
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    check("clr_pulse_high", 32'(oClr), 1);
    check("clr_busy", 32'(oBusy), 1);
    check("clr_valid_low", 32'(oValid), 0);
    iBitValid = 1'b1;
    iBit      = clr_bit;
    tick();
    iBitValid = 1'b0;
    check("clr_pulse_one_cycle", 32'(oClr), 0);
    check("run_busy", 32'(oBusy), 1);
  endtask

  // mode 0: all ones, 1: gapped 1/0, 2: random, 3: all zeros. Feeds n valid samples.
  task automatic feed(input int mode, input int n);
    int   accepted = 0;
    int   sum = 0;
    int   cyc = 0;
    logic v, b;
    while (accepted < n) begin
      case (mode)
        0:       begin v = 1'b1; b = 1'b1; end
        1:       begin v = (cyc % 2 == 0); b = (accepted % 2 == 0); end
        2:       begin v = ($urandom_range(0, 9) < 7); b = 1'($urandom_range(0, 1)); end
        default: begin v = 1'b1; b = 1'b0; end
      endcase
      iBitValid = v;
      iBit      = b;
      iStart    = 1'($urandom_range(0, 1));
      tick();
      cyc++;
      if (v) begin
        accepted++;
        sum += int'(b);
      end
      if (accepted < WINDOW) begin
        check("run_valid_low", 32'(oValid), 0);
        check("run_busy_high", 32'(oBusy), 1);
      end
    end
    iBitValid = 1'b0;
    iStart    = 1'b0;
    if (accepted == WINDOW) begin
      check("done_valid", 32'(oValid), 1);
      check("done_count", 32'(oCount), 32'(sum));
      check("done_busy_low", 32'(oBusy), 0);
      last_result = sum;
    end
  endtask

  // Handshake in DONE, optionally starting the next window on the same cycle.
  task automatic accept(input logic restart);
    iReady = 1'b1;
    iStart = restart;
    tick();
    iReady = 1'b0;
    iStart = 1'b0;
    check("accept_valid_low", 32'(oValid), 0);
    check("accept_clr", 32'(oClr), 32'(restart));
    check("accept_busy", 32'(oBusy), 32'(restart));
    check("accept_count_kept", 32'(oCount), 32'(last_result));
  endtask

  initial begin
    iRst = 1'b1; iStart = 1'b0; iAbort = 1'b0;
    iBit = 1'b0; iBitValid = 1'b0; iReady = 1'b0;
    #3;
    check("rst_clr", 32'(oClr), 0);
    check("rst_busy", 32'(oBusy), 0);
    check("rst_valid", 32'(oValid), 0);
    check("rst_count", 32'(oCount), 0);
    #4 iRst = 1'b0;
    tick();

    // Samples in IDLE are ignored and nothing starts without iStart.
    iBitValid = 1'b1; iBit = 1'b1;
    repeat (3) tick();
    iBitValid = 1'b0;
    check("idle_stays", 32'(oBusy), 0);

    // Full window of ones.
    start_window(1'b0);
    feed(0, WINDOW);
    check("all_ones_256", 32'(oCount), 32'(WINDOW));
    accept(1'b0);

    // Gapped stream: valid every other cycle, bits alternate 1,0.
    start_window(1'b1);
    feed(1, WINDOW);
    check("gapped_128", 32'(oCount), 32'(WINDOW / 2));
    accept(1'b0);

    // Random window, then back-pressure with noisy inputs, then back-to-back restart.
    start_window(1'b1);
    feed(2, WINDOW);
    for (int i = 0; i < 10; i++) begin
      iStart    = 1'($urandom_range(0, 1));
      iBitValid = 1'b1;
      iBit      = 1'($urandom_range(0, 1));
      tick();
      check("bp_valid_held", 32'(oValid), 1);
      check("bp_count_held", 32'(oCount), 32'(last_result));
    end
    iBitValid = 1'b0;
    accept(1'b1);
    iBitValid = 1'b1; iBit = 1'b1;
    tick();
    iBitValid = 1'b0;
    check("b2b_clr_done", 32'(oClr), 0);
    feed(2, WINDOW);
    accept(1'b0);

    // Abort after sample 100: no result, count untouched, next zero window reads 0.
    start_window(1'b0);
    feed(0, 100);
    iAbort = 1'b1; iStart = 1'b1;
    tick();
    iAbort = 1'b0; iStart = 1'b0;
    check("abort_busy", 32'(oBusy), 0);
    check("abort_valid", 32'(oValid), 0);
    check("abort_count_kept", 32'(oCount), 32'(last_result));
    tick();
    check("abort_idle", 32'(oBusy), 0);
    start_window(1'b1);
    feed(3, WINDOW);
    check("zeros_after_abort", 32'(oCount), 0);
    accept(1'b0);

    // Abort on the window-end edge wins over completion.
    start_window(1'b0);
    feed(0, WINDOW - 1);
    iBitValid = 1'b1; iBit = 1'b1; iAbort = 1'b1;
    tick();
    iBitValid = 1'b0; iAbort = 1'b0;
    check("abort_end_valid", 32'(oValid), 0);
    check("abort_end_busy", 32'(oBusy), 0);
    check("abort_end_count", 32'(oCount), 0);

    // Asynchronous reset at sample 50, then a clean full window.
    start_window(1'b0);
    feed(0, 50);
    #2 iRst = 1'b1;
    #1;
    check("midrst_clr", 32'(oClr), 0);
    check("midrst_busy", 32'(oBusy), 0);
    check("midrst_valid", 32'(oValid), 0);
    check("midrst_count", 32'(oCount), 0);
    #2 iRst = 1'b0;
    iBitValid = 1'b1; iBit = 1'b1;
    repeat (4) tick();
    iBitValid = 1'b0;
    check("post_rst_idle", 32'(oBusy), 0);
    start_window(1'b0);
    feed(0, WINDOW);
    check("post_rst_256", 32'(oCount), 32'(WINDOW));
    accept(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
